// File: rtl/ul_core_pkg.sv
// Shared definitions for the ul_core accumulator CPU: opcode encoding,
// sequencer states and small decode helpers.
// Optional feature macro: UL_CORE_SUB_EN (enables the SUB instruction).
package ul_core_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 3'd0,
    OP_LDA = 3'd1,
    OP_STA = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_JMP = 3'd5,
    OP_JZ  = 3'd6,
    OP_HLT = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_e;

  // True when the opcode has a real subtract implementation in this build.
  function automatic logic op_is_sub(input opcode_e op);
`ifdef UL_CORE_SUB_EN
    return (op == OP_SUB);
`else
    return 1'b0;
`endif
  endfunction

endpackage

// File: rtl/ul_alu.sv
// Combinational DATA_W-bit adder/subtractor for ul_core.
// carry_o is the carry out on add and the borrow on subtract.
module ul_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum_s;

  // One extra bit on the operands captures carry (add) or borrow (sub).
  always_comb begin
    sum_s = {(DATA_W+1){1'b0}};
    if (sub_i) begin
      sum_s = {1'b0, a_i} - {1'b0, b_i};
    end else begin
      sum_s = {1'b0, a_i} + {1'b0, b_i};
    end
  end

  assign res_o   = sum_s[DATA_W-1:0];
  assign carry_o = sum_s[DATA_W];

endmodule

// File: rtl/ul_core.sv
// ul_core: self-sequencing accumulator CPU with a req/ack memory port.
// Fetch/decode/execute sequencer, PC/IR/AR/accumulator/flags and bus
// selection live here; the adder/subtractor is ul_alu.
// Optional feature macro: UL_CORE_SUB_EN. When undefined, opcode 4 decodes
// as NOP and the ALU subtract input is tied low.
// DATA_W must be at least ADDR_W + 3 so opcode and operand do not overlap.
module ul_core
  import ul_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [DATA_W-1:0] akku_dbg,
  output logic              zero
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] akku_q, akku_d;
  logic              c_q, c_d;
  logic              z_q, z_d;

  opcode_e           opcode_s;
  logic [ADDR_W-1:0] operand_s;
  logic              req_s;
  logic              we_s;
  logic [ADDR_W-1:0] addr_s;
  logic              alu_sub_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_c_s;

  assign opcode_s  = opcode_e'(ir_q[DATA_W-1 -: OPC_W]);
  assign operand_s = ir_q[ADDR_W-1:0];

`ifdef UL_CORE_SUB_EN
  assign alu_sub_s = op_is_sub(opcode_s);
`else
  assign alu_sub_s = 1'b0;
`endif

  ul_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i     (akku_q),
    .b_i     (mem_rdata),
    .sub_i   (alu_sub_s),
    .res_o   (alu_res_s),
    .carry_o (alu_c_s)
  );

  // Architectural state: async clear to the documented reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= {ADDR_W{1'b0}};
      ir_q    <= {DATA_W{1'b0}};
      ar_q    <= {ADDR_W{1'b0}};
      akku_q  <= {DATA_W{1'b0}};
      c_q     <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ar_q    <= ar_d;
      akku_q  <= akku_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Sequencer: next state, register loads and memory request selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ar_d    = ar_q;
    akku_d  = akku_q;
    c_d     = c_q;
    z_d     = z_q;
    req_s   = 1'b0;
    we_s    = 1'b0;
    addr_s  = pc_q;

    case (state_q)
      FETCH: begin
        req_s  = 1'b1;
        addr_s = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1'b1);
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end

      DECODE: begin
        ar_d = operand_s;
        case (opcode_s)
          OP_HLT:  state_d = HALT;
          OP_NOP:  state_d = FETCH;
`ifndef UL_CORE_SUB_EN
          OP_SUB:  state_d = FETCH;
`endif
          default: state_d = EXEC;
        endcase
      end

      EXEC: begin
        case (opcode_s)
          OP_LDA: begin
            req_s  = 1'b1;
            addr_s = ar_q;
            if (mem_ack) begin
              akku_d  = mem_rdata;
              z_d     = (mem_rdata == {DATA_W{1'b0}});
              state_d = FETCH;
            end else begin
              state_d = EXEC;
            end
          end
`ifdef UL_CORE_SUB_EN
          OP_ADD, OP_SUB: begin
`else
          OP_ADD: begin
`endif
            req_s  = 1'b1;
            addr_s = ar_q;
            if (mem_ack) begin
              akku_d  = alu_res_s;
              c_d     = alu_c_s;
              z_d     = (alu_res_s == {DATA_W{1'b0}});
              state_d = FETCH;
            end else begin
              state_d = EXEC;
            end
          end
          OP_STA: begin
            req_s  = 1'b1;
            we_s   = 1'b1;
            addr_s = ar_q;
            if (mem_ack) begin
              state_d = FETCH;
            end else begin
              state_d = EXEC;
            end
          end
          OP_JMP: begin
            pc_d    = ar_q;
            state_d = FETCH;
          end
          OP_JZ: begin
            if (z_q) begin
              pc_d = ar_q;
            end else begin
              pc_d = pc_q;
            end
            state_d = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Requests are decoded from registered state only; reset removes the
  // request immediately so an in-flight access is abandoned.
  assign mem_req   = req_s & rst_n;
  assign mem_we    = we_s & rst_n;
  assign mem_addr  = addr_s;
  assign mem_wdata = akku_q;
  assign halted    = (state_q == HALT);
  assign akku_dbg  = akku_q;
  assign zero      = z_q;

endmodule

// File: tb/tb_ul_core.sv
// Directed, table-driven bench for ul_core with a req/ack memory model
// that supports a programmable number of wait cycles per request.
module tb_ul_core;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 8'h00;
  logic          mem_ack = 1'b0;
  logic          halted;
  logic [DW-1:0] akku_dbg;
  logic          zero;

  ul_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted),
    .akku_dbg  (akku_dbg),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory model -------------------------------------------------------
  logic [7:0]    mem [32];
  int            wait_n    = 0;
  int            cnt       = 0;
  int            n_req     = 0;
  logic          force_ack = 1'b0;
  logic [AW-1:0] sv_addr;
  logic          sv_we;
  logic [DW-1:0] sv_wdata;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_ack) cnt = 0;
      if (force_ack) begin
        mem_ack = 1'b1;
      end else if (mem_req) begin
        if (cnt == 0) begin
          sv_addr  = mem_addr;
          sv_we    = mem_we;
          sv_wdata = mem_wdata;
        end else begin
          chk("wait_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, sv_we, sv_addr, sv_wdata});
        end
        if (cnt >= wait_n) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          n_req++;
        end else begin
          mem_ack = 1'b0;
        end
        cnt++;
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Vector table -------------------------------------------------------
  typedef struct {
    string           name;
    logic [9:0][7:0] prog;
    logic [7:0]      m10, m11;
    logic            x_en;
    logic [4:0]      x_addr;
    logic [7:0]      x_word;
    int              wt;
    logic [7:0]      e_akku;
    logic            e_z, e_c;
    logic [7:0]      e_m12;
    int              e_cyc, e_req;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic logic [9:0][7:0] pg(input logic [7:0] a0, a1, a2,
      input logic [7:0] a3 = 8'h00, a4 = 8'h00, a5 = 8'h00, a6 = 8'h00,
      input logic [7:0] a7 = 8'h00, a8 = 8'h00, a9 = 8'h00);
    logic [9:0][7:0] p;
    p[0] = a0; p[1] = a1; p[2] = a2; p[3] = a3; p[4] = a4;
    p[5] = a5; p[6] = a6; p[7] = a7; p[8] = a8; p[9] = a9;
    return p;
  endfunction

  task automatic setv(input int k, input string nm, input logic [9:0][7:0] p,
                      input logic [7:0] m10, m11, input int wt,
                      input logic [7:0] ea, input logic ez, ec,
                      input logic [7:0] em12, input int ecyc, ereq);
    vecs[k].name = nm;   vecs[k].prog = p;
    vecs[k].m10 = m10;   vecs[k].m11 = m11;
    vecs[k].x_en = 1'b0; vecs[k].x_addr = 5'd0; vecs[k].x_word = 8'h00;
    vecs[k].wt = wt;     vecs[k].e_akku = ea;
    vecs[k].e_z = ez;    vecs[k].e_c = ec;
    vecs[k].e_m12 = em12;
    vecs[k].e_cyc = ecyc; vecs[k].e_req = ereq;
  endtask

  task automatic load_mem(input logic [9:0][7:0] p, input logic [7:0] m10, m11);
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    for (int i = 0; i < 10; i++) mem[i] = p[i];
    mem[10] = m10;
    mem[11] = m11;
    mem[12] = 8'hA5;
  endtask

  // Counts rising edges after release until halted; 0 means timeout.
  task automatic run_to_halt(output int cyc);
    cyc = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (halted) begin
        cyc = n;
        break;
      end
    end
  endtask

  int cyc;
  int found;

  initial begin
    // Encoding: opcode<<5 | addr. LDA=2x ADD=6x STA=4x SUB=8x JMP=Ax JZ=Cx HLT=E0
    setv(0, "lda_add_sta", pg(8'h2A, 8'h6B, 8'h4C, 8'hE0), 8'h7F, 8'h01, 0,
         8'h80, 1'b0, 1'b0, 8'h80, 11, 7);
    setv(1, "add_carry", pg(8'h2A, 8'h6B, 8'hE0), 8'hFF, 8'h01, 0,
         8'h00, 1'b1, 1'b1, 8'hA5, 8, 5);
`ifdef UL_CORE_SUB_EN
    setv(2, "sub", pg(8'h2A, 8'h8B, 8'hE0), 8'h05, 8'h03, 0,
         8'h02, 1'b0, 1'b0, 8'hA5, 8, 5);
    setv(3, "sub_borrow", pg(8'h2A, 8'h8B, 8'hE0), 8'h03, 8'h05, 0,
         8'hFE, 1'b0, 1'b1, 8'hA5, 8, 5);
`else
    setv(2, "sub_as_nop", pg(8'h2A, 8'h8B, 8'hE0), 8'h05, 8'h03, 0,
         8'h05, 1'b0, 1'b0, 8'hA5, 7, 4);
    setv(3, "sub_as_nop2", pg(8'h2A, 8'h8B, 8'hE0), 8'h03, 8'h05, 0,
         8'h03, 1'b0, 1'b0, 8'hA5, 7, 4);
`endif
    setv(4, "jz_taken", pg(8'h2A, 8'hC7, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2B, 8'h4C, 8'hE0),
         8'h00, 8'h33, 0, 8'h33, 1'b0, 1'b0, 8'h33, 14, 8);
    setv(5, "jz_fall", pg(8'h2A, 8'hC7, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2B, 8'h4C, 8'hE0),
         8'h05, 8'h33, 0, 8'h05, 1'b0, 1'b0, 8'hA5, 8, 4);
    setv(6, "jmp", pg(8'hA5, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h2A, 8'hE0),
         8'h80, 8'h00, 0, 8'h80, 1'b0, 1'b0, 8'hA5, 8, 4);
    setv(7, "nop", pg(8'h00, 8'h2A, 8'hE0), 8'h11, 8'h00, 0,
         8'h11, 1'b0, 1'b0, 8'hA5, 7, 4);
    setv(8, "wait3", pg(8'h2A, 8'hE0, 8'h00), 8'h3C, 8'h00, 3,
         8'h3C, 1'b0, 1'b0, 8'hA5, 14, 3);
    setv(9, "pc_wrap", pg(8'hDF, 8'hE0, 8'h00), 8'h07, 8'h00, 0,
         8'h07, 1'b0, 1'b0, 8'hA5, 11, 5);
    vecs[9].x_en = 1'b1; vecs[9].x_addr = 5'd31; vecs[9].x_word = 8'h2A;
    setv(10, "jz_wait1", pg(8'h2A, 8'hC7, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2B, 8'h4C, 8'hE0),
         8'h00, 8'h33, 1, 8'h33, 1'b0, 1'b0, 8'h33, 22, 8);

    for (int k = 0; k < NV; k++) begin
      rst_n  = 1'b0;
      wait_n = vecs[k].wt;
      load_mem(vecs[k].prog, vecs[k].m10, vecs[k].m11);
      if (vecs[k].x_en) mem[vecs[k].x_addr] = vecs[k].x_word;
      repeat (2) @(posedge clk);
      #1;
      chk({vecs[k].name, "/rst_ctl"}, {mem_req, mem_we, halted, zero}, 4'b0001);
      chk({vecs[k].name, "/rst_data"}, {akku_dbg, mem_wdata, 3'b000, mem_addr}, 24'h0);
      n_req = 0;
      #1 rst_n = 1'b1;
      run_to_halt(cyc);
      chk({vecs[k].name, "/cycles"}, cyc, vecs[k].e_cyc);
      chk({vecs[k].name, "/akku"}, akku_dbg, vecs[k].e_akku);
      chk({vecs[k].name, "/zero"}, zero, vecs[k].e_z);
      chk({vecs[k].name, "/carry"}, dut.c_q, vecs[k].e_c);
      chk({vecs[k].name, "/m12"}, mem[12], vecs[k].e_m12);
      chk({vecs[k].name, "/requests"}, n_req, vecs[k].e_req);
      repeat (3) @(posedge clk);
      #1;
      chk({vecs[k].name, "/halt_idle"}, {halted, mem_req}, 2'b10);
    end

    // Reset during a STA wait: request drops at once, stray ack ignored.
    rst_n  = 1'b0;
    wait_n = 5;
    load_mem(pg(8'h2A, 8'h4C, 8'hE0), 8'h5A, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    found = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (mem_req && mem_we) begin
        found = 1;
        break;
      end
    end
    chk("sta_wait_seen", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drops_req", {mem_req, mem_we}, 2'b00);
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    force_ack = 1'b0;
    wait_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_write", mem[12], 8'hA5);
    chk("rst_state", {halted, zero, akku_dbg}, {1'b0, 1'b1, 8'h00});
    #1 rst_n = 1'b1;
    #1;
    chk("first_req_read0", {mem_req, mem_we, 3'b000, mem_addr}, {2'b10, 8'h00});
    run_to_halt(cyc);
    chk("rerun_cycles", cyc, 8);
    chk("rerun_akku", akku_dbg, 8'h5A);
    chk("rerun_m12", mem[12], 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
